// File: rtl/float12_to_fixed.sv
// -----------------------------------------------------------------------------
// float12_to_fixed
//
// Converts the 12-bit float format of the float datapath (sign[11],
// exponent[10:6] biased 15, mantissa[5:0] with hidden 1) into signed
// two's-complement fixed point with FRAC_W fractional bits in OUT_W bits.
// Three register stages with valid/ready flow control; the magnitude is
// saturated symmetrically to +/-(2^(OUT_W-1)-1) and ovf_o flags it.
//
// Build option:
//   F2X_ROUND_EN  defined   -> round half away from zero (round bit only)
//                 undefined -> truncate magnitude (round toward zero)
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_n_i  in   asynchronous active-low reset
//   data_i   in   float12 operand
//   valid_i  in   data_i valid
//   ready_o  out  data_i accepted this cycle (= advance enable)
//   data_o   out  signed fixed-point result, scaled by 2^FRAC_W
//   ovf_o    out  result saturated, qualified by valid_o
//   valid_o  out  data_o / ovf_o valid
//   ready_i  in   downstream accepts data_o
// -----------------------------------------------------------------------------
module float12_to_fixed #(
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [11:0]      data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             ovf_o,
    output logic             valid_o,
    input  logic             ready_i
);

    // Largest left shift is e=31: sh = 10+FRAC_W, so a 7-bit significand
    // needs 17+FRAC_W bits. The path is also at least OUT_W bits so the
    // saturation limit is representable, plus one spare bit.
    localparam int MAG_A = 17 + FRAC_W;
    localparam int MAG_W = ((MAG_A > OUT_W) ? MAG_A : OUT_W) + 1;

    localparam logic [MAG_W-1:0] MAXM    = MAG_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic [OUT_W-2:0] MAXM_O  = {(OUT_W-1){1'b1}};
    localparam logic [6:0]       SH_FRAC = 7'(FRAC_W);

    // Round bit of a right shift by r (r >= 1): the MSB of the discarded
    // bits, which is zero once r exceeds the significand width.
    function automatic logic round_bit(input logic [6:0] m, input logic [6:0] r);
        logic [6:0] t;
        t = m >> (r - 7'd1);
        return t[0];
    endfunction

    logic adv_s;

    // Stage 1 registers
    logic       v1_q,    v1_d;
    logic       zero1_q, zero1_d;
    logic       sign1_q, sign1_d;
    logic [6:0] m1_q,    m1_d;
    logic [6:0] sh1_q,   sh1_d;     // two's complement, bit 6 = negative

    // Stage 2 registers
    logic             v2_q,    v2_d;
    logic             sign2_q, sign2_d;
    logic             ovf2_q,  ovf2_d;
    logic [OUT_W-2:0] mag2_q,  mag2_d;

    // Stage 3 registers (the outputs)
    logic             v3_q,    v3_d;
    logic             ovf3_q,  ovf3_d;
    logic [OUT_W-1:0] data3_q, data3_d;

    // Stage 2 datapath
    logic [MAG_W-1:0] m_ext_s;
    logic [6:0]       rsh_s;
    logic [MAG_W-1:0] mag_s;
    logic [MAG_W-1:0] mag_rnd_s;

    // Stage 3 datapath
    logic [OUT_W-2:0] mag_sat_s;

    // Whole pipe moves when the output slot is free or being drained.
    always_comb begin
        adv_s   = ready_i | ~v3_q;
        ready_o = adv_s;
    end

    // S1: split fields, flag flush-to-zero, compute signed shift amount.
    always_comb begin
        v1_d    = valid_i;
        zero1_d = (data_i[10:6] == 5'd0);
        sign1_d = data_i[11];
        m1_d    = {1'b1, data_i[5:0]};
        // e - 21 + FRAC_W taken modulo 128; bit 6 is the sign.
        sh1_d   = {2'b00, data_i[10:6]} + SH_FRAC - 7'd21;
    end

    // S2: barrel shift of the significand into the wide magnitude path.
    always_comb begin
        m_ext_s = {{(MAG_W-7){1'b0}}, m1_q};
        rsh_s   = 7'd0 - sh1_q;
        mag_s   = {MAG_W{1'b0}};
        if (zero1_q) begin
            mag_s = {MAG_W{1'b0}};
        end else if (!sh1_q[6]) begin
            mag_s = m_ext_s << sh1_q[5:0];
        end else begin
            mag_s = m_ext_s >> rsh_s;
        end
    end

`ifdef F2X_ROUND_EN
    logic rbit_s;

    // S2: add the round bit on right shifts (ties go up in magnitude).
    always_comb begin
        rbit_s = 1'b0;
        if (!zero1_q && sh1_q[6]) begin
            rbit_s = round_bit(m1_q, rsh_s);
        end else begin
            rbit_s = 1'b0;
        end
        mag_rnd_s = mag_s + {{(MAG_W-1){1'b0}}, rbit_s};
    end
`else
    // S2: truncation; the magnitude passes through unchanged.
    always_comb begin
        mag_rnd_s = mag_s;
    end
`endif

    // S2: overflow detect on the full-width rounded magnitude.
    always_comb begin
        v2_d    = v1_q;
        sign2_d = sign1_q & ~zero1_q;
        ovf2_d  = (mag_rnd_s > MAXM);
        mag2_d  = mag_rnd_s[OUT_W-2:0];
    end

    // S3: clip to the symmetric limit, then apply the sign.
    always_comb begin
        v3_d   = v2_q;
        ovf3_d = ovf2_q;
        if (ovf2_q) begin
            mag_sat_s = MAXM_O;
        end else begin
            mag_sat_s = mag2_q;
        end
        if (sign2_q) begin
            data3_d = {OUT_W{1'b0}} - {1'b0, mag_sat_s};
        end else begin
            data3_d = {1'b0, mag_sat_s};
        end
    end

    // Pipeline registers: all stages load together on advance, hold otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1_q    <= 1'b0;
            zero1_q <= 1'b0;
            sign1_q <= 1'b0;
            m1_q    <= 7'd0;
            sh1_q   <= 7'd0;
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            ovf2_q  <= 1'b0;
            mag2_q  <= {(OUT_W-1){1'b0}};
            v3_q    <= 1'b0;
            ovf3_q  <= 1'b0;
            data3_q <= {OUT_W{1'b0}};
        end else if (adv_s) begin
            v1_q    <= v1_d;
            zero1_q <= zero1_d;
            sign1_q <= sign1_d;
            m1_q    <= m1_d;
            sh1_q   <= sh1_d;
            v2_q    <= v2_d;
            sign2_q <= sign2_d;
            ovf2_q  <= ovf2_d;
            mag2_q  <= mag2_d;
            v3_q    <= v3_d;
            ovf3_q  <= ovf3_d;
            data3_q <= data3_d;
        end else begin
            v1_q    <= v1_q;
            v2_q    <= v2_q;
            v3_q    <= v3_q;
        end
    end

    // Outputs come straight from the stage-3 registers.
    always_comb begin
        data_o  = data3_q;
        ovf_o   = ovf3_q;
        valid_o = v3_q;
    end

endmodule

// File: tb/tb_float12_to_fixed.sv
// -----------------------------------------------------------------------------
// tb_float12_to_fixed
//
// Scoreboard bench: the driver sets the expected response alongside each
// operand; an acceptor pushes it on every handshake and an independent
// monitor pops and compares whenever a result transfers. Inputs change 1
// time unit after the rising edge, everything is sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_float12_to_fixed;

    localparam int FRAC_W = 8;
    localparam int OUT_W  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] din;
    logic        vin;
    logic        rdy_o;
    logic [15:0] dout;
    logic        ovfo;
    logic        vout;
    logic        rdy_in;

    float12_to_fixed #(.FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (din),
        .valid_i (vin),
        .ready_o (rdy_o),
        .data_o  (dout),
        .ovf_o   (ovfo),
        .valid_o (vout),
        .ready_i (rdy_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_cmp = 0;
    int          cyc   = 0;
    logic [15:0] exp_d_cur;
    logic        exp_o_cur;
    bit          lat_cur;
    bit          held_v;
    logic [15:0] held_d;
    logic        held_o;
    bit          saw_stall;

    // Directed vectors with hand-computed results.
    localparam int NDIR = 15;
    logic [11:0] tab_x [NDIR];
    logic [15:0] tab_d [NDIR];
    logic        tab_o [NDIR];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    // Independent reference: integer arithmetic on the decoded value.
    function automatic logic [16:0] ref_f(input logic [11:0] x);
        int     e;
        int     sh;
        longint mm;
        longint mag;
        logic   o;
        logic [15:0] d;
        e = int'(x[10:6]);
        if (e == 0) return 17'd0;
        mm = 64'd64 + longint'(x[5:0]);
        sh = e - 21 + FRAC_W;
        if (sh >= 0) begin
            mag = mm << sh;
        end else begin
            mag = mm >> (-sh);
`ifdef F2X_ROUND_EN
            if (((mm >> (-sh - 1)) & 64'd1) == 64'd1) mag = mag + 64'd1;
`endif
        end
        o = (mag > 64'd32767);
        if (o) mag = 64'd32767;
        d = x[11] ? 16'(-mag) : 16'(mag);
        return {o, d};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptor: record the expected response of every accepted operand.
    always @(negedge clk) begin
        if (rst_n && vin && rdy_o) begin
            sb.push_back('{exp_d_cur, exp_o_cur, cyc, lat_cur});
            n_vec++;
        end
    end

    // Monitor: flow-control rules, hold during stall, and result compare.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_o", {31'd0, rdy_o}, {31'd0, rdy_in | ~vout});
            if (vout && !rdy_in && !rdy_o) saw_stall = 1'b1;
            if (held_v) begin
                chk("hold_valid", {31'd0, vout}, 32'd1);
                chk("hold_data", {16'd0, dout}, {16'd0, held_d});
                chk("hold_ovf", {31'd0, ovfo}, {31'd0, held_o});
            end
            if (vout && rdy_in) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected none", dout);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_o", {16'd0, dout}, {16'd0, e.d});
                    chk("ovf_o", {31'd0, ovfo}, {31'd0, e.o});
                    if (e.lat) chk("latency", cyc - e.acc, 32'd3);
                end
            end
            held_v = vout && !rdy_in;
            held_d = dout;
            held_o = ovfo;
        end
    end

    // Present one operand and wait (bounded) until it is accepted.
    task automatic send(input logic [11:0] x, input logic [15:0] ed, input logic eo, input bit lat);
        bit ok;
        din       = x;
        exp_d_cur = ed;
        exp_o_cur = eo;
        lat_cur   = lat;
        vin       = 1'b1;
        ok        = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got ready_o=0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [16:0] r;
        tab_x[0]  = 12'h3C0; tab_d[0]  = 16'h0100; tab_o[0]  = 1'b0;
        tab_x[1]  = 12'hC10; tab_d[1]  = 16'hFD80; tab_o[1]  = 1'b0;
        tab_x[2]  = 12'h000; tab_d[2]  = 16'h0000; tab_o[2]  = 1'b0;
        tab_x[3]  = 12'h800; tab_d[3]  = 16'h0000; tab_o[3]  = 1'b0;
        tab_x[4]  = 12'h03F; tab_d[4]  = 16'h0000; tab_o[4]  = 1'b0;
        tab_x[5]  = 12'h7C0; tab_d[5]  = 16'h7FFF; tab_o[5]  = 1'b1;
        tab_x[6]  = 12'hFC0; tab_d[6]  = 16'h8001; tab_o[6]  = 1'b1;
        tab_x[7]  = 12'h57F; tab_d[7]  = 16'h7F00; tab_o[7]  = 1'b0;
        tab_x[8]  = 12'h580; tab_d[8]  = 16'h7FFF; tab_o[8]  = 1'b1;
        tab_x[9]  = 12'hD80; tab_d[9]  = 16'h8001; tab_o[9]  = 1'b1;
        tab_x[10] = 12'h3C1; tab_d[10] = 16'h0104; tab_o[10] = 1'b0;
        tab_x[11] = 12'h0BF; tab_d[11] = 16'h0000; tab_o[11] = 1'b0;
`ifdef F2X_ROUND_EN
        tab_x[12] = 12'h180; tab_d[12] = 16'h0001; tab_o[12] = 1'b0;
        tab_x[13] = 12'h2C3; tab_d[13] = 16'h0011; tab_o[13] = 1'b0;
        tab_x[14] = 12'hAC3; tab_d[14] = 16'hFFEF; tab_o[14] = 1'b0;
`else
        tab_x[12] = 12'h180; tab_d[12] = 16'h0000; tab_o[12] = 1'b0;
        tab_x[13] = 12'h2C3; tab_d[13] = 16'h0010; tab_o[13] = 1'b0;
        tab_x[14] = 12'hAC3; tab_d[14] = 16'hFFF0; tab_o[14] = 1'b0;
`endif
        rst_n     = 1'b0;
        din       = 12'h000;
        vin       = 1'b0;
        rdy_in    = 1'b1;
        held_v    = 1'b0;
        saw_stall = 1'b0;
        exp_d_cur = 16'h0000;
        exp_o_cur = 1'b0;
        lat_cur   = 1'b0;
        #12;
        chk("reset_valid", {31'd0, vout}, 32'd0);
        chk("reset_data", {16'd0, dout}, 32'd0);
        chk("reset_ovf", {31'd0, ovfo}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Isolated vectors: value plus exact latency.
        for (int i = 0; i < NDIR; i++) begin
            send(tab_x[i], tab_d[i], tab_o[i], 1'b1);
            idle(4);
        end

        // Back-to-back stream with the output stalled for cycles 4..7.
        fork
            begin
                for (int i = 0; i < 10; i++) send(tab_x[i + 5], tab_d[i + 5], tab_o[i + 5], 1'b0);
                vin = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 rdy_in = 1'b0;
                repeat (4) @(posedge clk);
                #1 rdy_in = 1'b1;
            end
        join
        idle(8);
        chk("stall_seen", {31'd0, saw_stall}, 32'd1);
        chk("stream_drained", sb.size(), 32'd0);

        // Asynchronous reset with three items in flight.
        for (int i = 0; i < 3; i++) send(tab_x[i], tab_d[i], tab_o[i], 1'b0);
        vin = 1'b0;
        #1 rst_n = 1'b0;
        sb.delete();
        held_v = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, vout}, 32'd0);
        chk("rst_mid_data", {16'd0, dout}, 32'd0);
        #1 rst_n = 1'b1;
        idle(6);
        send(12'h3C0, 16'h0100, 1'b0, 1'b1);
        idle(6);
        chk("post_reset_drained", sb.size(), 32'd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            din       = 12'($urandom);
            r         = ref_f(din);
            exp_d_cur = r[15:0];
            exp_o_cur = r[16];
            lat_cur   = 1'b0;
            vin       = 1'($urandom_range(0, 1));
            rdy_in    = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        vin    = 1'b0;
        rdy_in = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("final_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
